// File: rtl/fp_pkg.sv
// Shared IEEE754 single-precision constants and FSM state type for the FP
// calculator arithmetic units.
package fp_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;
  localparam logic [31:0] ONE  = 32'h3F800000;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root step: consumes two radicand bits
// and produces the next root bit plus the updated partial remainder.
module isqrt_step #(
  parameter int RW = 24
) (
  input  logic [RW+1:0] i_rem,
  input  logic [1:0]    i_bits,
  input  logic [RW-1:0] i_root,
  output logic [RW+1:0] o_rem,
  output logic          o_bit
);
  localparam int TW = RW + 5;

  logic [TW-1:0] w_lhs;
  logic [TW-1:0] w_rhs;
  logic [TW-1:0] w_trial;

  always_comb begin
    w_lhs   = {1'b0, i_rem, i_bits};
    w_rhs   = {3'b000, i_root, 2'b01};
    w_trial = w_lhs - w_rhs;
    o_bit   = ~w_trial[TW-1];
    // The true remainder never exceeds 2*root, so dropping the top bits is lossless.
    o_rem   = o_bit ? w_trial[RW+1:0] : w_lhs[RW+1:0];
  end
endmodule

// File: rtl/fp_sqrt.sv
// Iterative IEEE754 single-precision square root, one root bit per clock.
// Define FP_SQRT_ROUND_EN to add a guard iteration and round the mantissa.
module fp_sqrt
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int BIAS  = FP_BIAS
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic                   start,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   enable,
  output logic                   busy,
  output logic                   invalid,
  output logic                   overflow,
  output logic                   underflow
);
`ifdef FP_SQRT_ROUND_EN
  localparam int ITER = MAN_W + 2;
`else
  localparam int ITER = MAN_W + 1;
`endif
  localparam int RW  = ITER;
  localparam int RADW = 2 * (MAN_W + 1);

  state_t                 r_state, w_state_nxt;
  logic [RADW-1:0]        r_rad;
  logic [RW+1:0]          r_rem;
  logic [RW-1:0]          r_root;
  logic [4:0]             r_cnt;
  logic [EXP_W-1:0]       r_exp;
  logic [EXP_W+MAN_W:0]   r_result;
  logic                   r_invalid;
  logic                   r_underflow;

  logic                   w_accept, w_last;
  logic                   w_s;
  logic [EXP_W-1:0]       w_e;
  logic [MAN_W-1:0]       w_f;
  logic                   w_special, w_spec_inv, w_spec_unf;
  logic [EXP_W+MAN_W:0]   w_spec_res;
  logic [EXP_W:0]         w_exp9;
  logic [RADW-1:0]        w_rad_init;
  logic [RW+1:0]          w_rem_nxt;
  logic                   w_bit;
  logic [RW-1:0]          w_root_fin;
  logic [EXP_W+MAN_W:0]   w_norm_res;
`ifdef FP_SQRT_ROUND_EN
  logic [MAN_W+1:0]       w_sum;
`endif

  isqrt_step #(.RW(RW)) u_step (
    .i_rem  (r_rem),
    .i_bits (r_rad[RADW-1:RADW-2]),
    .i_root (r_root),
    .o_rem  (w_rem_nxt),
    .o_bit  (w_bit)
  );

  // Operand classification and special-case results.
  always_comb begin
    w_s        = A[EXP_W+MAN_W];
    w_e        = A[EXP_W+MAN_W-1:MAN_W];
    w_f        = A[MAN_W-1:0];
    w_special  = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_unf = 1'b0;
    w_spec_res = QNAN;
    if (w_e == '1) begin
      if (w_f != '0)  w_spec_res = QNAN;
      else if (w_s) begin
        w_spec_res = QNAN;
        w_spec_inv = 1'b1;
      end else        w_spec_res = PINF;
    end else if (w_e == '0) begin
      w_spec_res = {w_s, {(EXP_W+MAN_W){1'b0}}};
      w_spec_unf = (w_f != '0);
    end else if (w_s) begin
      w_spec_res = QNAN;
      w_spec_inv = 1'b1;
    end else begin
      w_special  = 1'b0;
    end
    // Odd exponents keep the radicand one bit lower so the halved exponent is exact.
    w_exp9     = {1'b0, w_e} + (EXP_W+1)'(BIAS) - {{EXP_W{1'b0}}, ~w_e[0]};
    w_rad_init = w_e[0] ? {1'b0, 1'b1, w_f, {MAN_W{1'b0}}}
                        : {1'b1, w_f, {(MAN_W+1){1'b0}}};
  end

  always_comb begin
    w_root_fin = {r_root[RW-2:0], w_bit};
`ifdef FP_SQRT_ROUND_EN
    w_sum      = {1'b0, w_root_fin[RW-1:1]} + {{(MAN_W+1){1'b0}}, w_root_fin[0]};
    w_norm_res = {1'b0, r_exp + {{(EXP_W-1){1'b0}}, w_sum[MAN_W+1]}, w_sum[MAN_W-1:0]};
`else
    w_norm_res = {1'b0, r_exp, w_root_fin[MAN_W-1:0]};
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = w_special ? DONE : CALC;
      end
      CALC: if (r_cnt == 5'd1) begin
        w_last      = 1'b1;
        w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_exp       <= '0;
      r_result    <= '0;
      r_invalid   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_invalid   <= w_special & w_spec_inv;
        r_underflow <= w_special & w_spec_unf;
        if (w_special) r_result <= w_spec_res;
        r_rad  <= w_rad_init;
        r_rem  <= '0;
        r_root <= '0;
        r_cnt  <= w_special ? 5'd0 : 5'(ITER);
        r_exp  <= w_exp9[EXP_W:1];
      end else if (r_state == CALC) begin
        r_rad  <= {r_rad[RADW-3:0], 2'b00};
        r_rem  <= w_rem_nxt;
        r_root <= w_root_fin;
        r_cnt  <= r_cnt - 5'd1;
        if (w_last) r_result <= w_norm_res;
      end
    end
  end

  assign result    = r_result;
  assign enable    = (r_state == DONE);
  assign busy      = (r_state == CALC);
  assign invalid   = r_invalid;
  assign overflow  = 1'b0;
  assign underflow = r_underflow;
endmodule

// File: tb/tb_fp_sqrt.sv
// Directed self-checking bench for fp_sqrt: normal roots, special operands,
// reset abort, ignored starts during CALC and back-to-back operation.
module tb_fp_sqrt;
`ifdef FP_SQRT_ROUND_EN
  localparam int          LAT   = 26;
  localparam logic [31:0] R_5_0 = 32'h400F1BBD;
`else
  localparam int          LAT   = 25;
  localparam logic [31:0] R_5_0 = 32'h400F1BBC;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] A = '0;
  logic        start = 1'b0;
  logic [31:0] result;
  logic        enable, busy, invalid, overflow, underflow;
  int          n_tests = 0;
  int          n_fail  = 0;

  fp_sqrt dut (
    .CLK(CLK), .RST(RST), .A(A), .start(start), .result(result),
    .enable(enable), .busy(busy), .invalid(invalid),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  // Present start for one cycle, then count edges until enable (bounded).
  task automatic run_op(input logic [31:0] a, output int lat, output int bcnt);
    @(posedge CLK); #1;
    A = a; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 1; bcnt = busy ? 1 : 0;
    while (!enable && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++;
    if ({result, enable, busy, invalid, overflow, underflow} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset: got res=%h en=%b busy=%b inv=%b ovf=%b unf=%b, want all 0",
               result, enable, busy, invalid, overflow, underflow);
    end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_normal();
    logic [31:0] ins [4] = '{32'h40800000, 32'h3E800000, 32'h40000000, 32'h40A00000};
    logic [31:0] exp_r [4] = '{32'h40000000, 32'h3F000000, 32'h3FB504F3, R_5_0};
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      run_op(ins[i], lat, bcnt);
      n_tests++;
      if (result !== exp_r[i] || invalid !== 1'b0 || underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL normal_%h: got res=%h inv=%b unf=%b, want %h 0 0",
                 ins[i], result, invalid, underflow, exp_r[i]);
      end
      n_tests++;
      if (lat !== LAT || bcnt !== LAT - 1) begin
        n_fail++;
        $display("FAIL latency_%h: got lat=%0d busy=%0d, want %0d %0d",
                 ins[i], lat, bcnt, LAT, LAT - 1);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] ins [5]   = '{32'hC0800000, 32'h80000000, 32'h7F800000, 32'h7FA00000, 32'h00000001};
    logic [31:0] exp_r [5] = '{32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h00000000};
    logic        exp_i [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        exp_u [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      run_op(ins[i], lat, bcnt);
      n_tests++;
      if (lat !== 1 || bcnt !== 0 || result !== exp_r[i] || invalid !== exp_i[i] ||
          underflow !== exp_u[i] || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL special_%h: got lat=%0d res=%h inv=%b unf=%b ovf=%b, want 1 %h %b %b 0",
                 ins[i], lat, result, invalid, underflow, overflow, exp_r[i], exp_i[i], exp_u[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1;
    A = 32'h40800000; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (8) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    n_tests++;
    if (result !== 32'd0 || enable !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got res=%h en=%b busy=%b, want 0 0 0", result, enable, busy);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(posedge CLK); #1;
    A = 32'h40800000; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; lat = 1;
    while (!enable && lat < 40) begin
      if (lat == 5 || lat == 12) begin A = 32'hC0800000; start = 1'b1; end
      else begin A = 32'h40800000; start = 1'b0; end
      @(posedge CLK); #1;
      lat++;
    end
    start = 1'b0;
    n_tests++;
    if (lat !== LAT || result !== 32'h40000000 || invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: got lat=%0d res=%h inv=%b, want %0d 40000000 0",
               lat, result, invalid, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    run_op(32'h40800000, lat, bcnt);
    A = 32'h41100000; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    n_tests++;
    if (enable !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drop: got en=%b busy=%b, want 0 1", enable, busy);
    end
    lat = 1;
    while (!enable && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    n_tests++;
    if (lat !== LAT || result !== 32'h40400000) begin
      n_fail++;
      $display("FAIL b2b_result: got lat=%0d res=%h, want %0d 40400000", lat, result, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_sqrt.md
Name: fp_sqrt

Overview:
- Iterative IEEE754 single-precision square-root unit for the FP calculator datapath; the inverse of the power/squaring block.
- Takes operand A on a start pulse and computes the 24-bit root mantissa one bit per clock with a digit-by-digit (restoring) integer square root.
- Raises enable when result is valid; output flags follow the calculator's arithmetic-unit convention.

Parameters:
- EXP_W, 8, exponent field width (only 8 supported/verified)
- MAN_W, 23, stored mantissa width (only 23 supported/verified)
- BIAS, 127, exponent bias

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- A  in  32  IEEE754 single operand, sampled on the accepting start edge
- start  in  1  one-cycle request; accepted in IDLE or DONE only
- result  out  32  IEEE754 root, held until next accepted start
- enable  out  1  result valid (level), high in DONE
- busy  out  1  high in CALC
- invalid  out  1  operation invalid (negative non-zero input), valid with enable
- overflow  out  1  constant 0 (sqrt cannot overflow)
- underflow  out  1  high when a denormal input was flushed; valid with enable

Behaviour:
- Reset (RST=1 at rising edge): state=IDLE; result=0, enable=0, busy=0, invalid=0, underflow=0; counter and work registers cleared. Reset mid-CALC aborts with no partial result.
- FSM has three states: IDLE, CALC, DONE.
- IDLE or DONE with start=1: latch A and classify.
  - Special operand: go to DONE; enable=1 one clock after the start edge.
  - Normal operand: go to CALC with counter=24; enable drops.
- start while in CALC is ignored.
- Special cases, sign s:
  - ±0 gives ±0.
  - +inf gives 0x7F800000.
  - Any NaN gives 0x7FC00000.
  - Negative non-zero (incl. -inf) gives 0x7FC00000 with invalid=1.
  - Denormal (exp=0, frac≠0) gives signed zero with underflow=1.
- Normal setup:
  - M = {1,frac}.
  - expA odd: radicand R = {1'b0,M,23'b0} (48b); result exp = (expA+127)>>1.
  - expA even: R = {M,24'b0}; result exp = (expA+126)>>1.
  - Exponent arithmetic uses 9-bit intermediates. Result sign is 0.
- CALC performs one restoring step per edge on a 48-bit R shifting 2 bits per step, a 26-bit remainder and a 24-bit root.
  - trial = {rem,next2bits} − {root,2'b01}.
  - If trial is non-negative, rem = trial and root bit = 1; else root bit = 0.
- On the 24th CALC edge: root[23] is always 1, so no normalisation is needed. result = {0,exp,root[22:0]} (truncation). Go to DONE.
- Latency: enable is high 25 clocks after the start edge for normal operands, 1 clock after for special operands.
- DONE holds result and flags until the next accepted start; a new start in DONE behaves exactly as in IDLE.

Optional Feature:
- Macro FP_SQRT_ROUND_EN.
- Defined:
  - One extra CALC iteration (counter=25) yields guard bit g; exact ties cannot occur for sqrt.
  - Mantissa = root[23:0]+g. On carry-out, mantissa becomes 0 and exp+1.
  - Normal latency becomes 26; special-case latency is unchanged.
- Undefined: truncation as above, latency 25.

Decomposition:
- Shared package fp_pkg holds:
  - Field widths and BIAS.
  - Constants QNAN=32'h7FC00000, PINF=32'h7F800000, ONE=32'h3F800000.
  - State enum {IDLE,CALC,DONE}.
- Sub-module isqrt_step: combinational single restoring step.
  - Inputs: rem, two radicand bits, root.
  - Outputs: new rem, new root bit.
  - Instantiated once and reused each cycle.

Test Plan:
- A=0x40800000 (4.0), start → enable at +25 clocks, result=0x40000000, invalid=0, underflow=0; busy high for exactly 24 clocks.
- A=0x3E800000 (0.25) → 0x3F000000. A=0x40000000 (2.0) → 0x3FB504F3, same value with and without FP_SQRT_ROUND_EN.
- A=0x40A00000 (5.0) → 0x400F1BBC without FP_SQRT_ROUND_EN (latency 25); 0x400F1BBD with it (latency 26).
- A=0xC0800000 → 0x7FC00000, invalid=1 at +1 clock. A=0x80000000 → 0x80000000. A=0x7F800000 → 0x7F800000. A=0x7FA00000 → 0x7FC00000. A=0x00000001 → 0x00000000, underflow=1.
- start 4.0, RST=1 at clock 10 → next edge result=0, enable=0, busy=0. start pulses during CALC are ignored and the original result is unaffected.
- Back-to-back: start 4.0, then at DONE start 9.0 (0x41100000) the same cycle → enable drops next edge, rises 25 clocks later, result=0x40400000.
